// File: rtl/seq_hit_logger_if.sv
// seq_hit_logger_if
//   Drain bus of the hit logger: the head timestamp of the FIFO is
//   offered on ts_data while ts_valid is high and is removed at a
//   rising edge where ts_ready is also high.
//
//   Signals
//     ts_valid  logger -> consumer  FIFO non-empty
//     ts_ready  consumer -> logger  consumer accepts the head entry
//     ts_data   logger -> consumer  head timestamp (0 when empty)
//
//   Modports
//     master : the logger (drives valid/data)
//     slave  : the consumer (drives ready)
interface seq_hit_logger_if #(
    parameter int TS_W = 16
);
    logic            ts_valid;
    logic            ts_ready;
    logic [TS_W-1:0] ts_data;

    modport master (
        output ts_valid,
        output ts_data,
        input  ts_ready
    );

    modport slave (
        input  ts_valid,
        input  ts_data,
        output ts_ready
    );
endinterface

// File: rtl/seq_hit_logger.sv
// seq_hit_logger
//   Time-stamps every single-cycle detection pulse from the 1001 sequence
//   detector against a free-running cycle counter and queues the stamps
//   in a small FIFO drained over a valid/ready bus. Also keeps a
//   saturating hit count and a sticky overflow flag for hits that were
//   dropped because the FIFO was full.
//
//   Parameters
//     TS_W   timestamp counter / FIFO entry width
//     DEPTH  FIFO depth in entries (power of two, >= 2)
//     CNT_W  hit counter width
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous active-low reset
//     hit        detection pulse, one event per high cycle
//     clr        synchronous clear of FIFO, hit_count and overflow
//     ts_if      drain bus (master side): ts_valid / ts_ready / ts_data
//     level      FIFO occupancy, 0..DEPTH
//     hit_count  hits since reset/clr, saturating
//     overflow   sticky: a hit was dropped on a full FIFO
//
//   All outputs come straight from flops or are decoded from flops only.
module seq_hit_logger #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hit,
    input  logic                    clr,
    seq_hit_logger_if.master        ts_if,
    output logic [$clog2(DEPTH):0]  level,
    output logic [CNT_W-1:0]        hit_count,
    output logic                    overflow
);
    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int                LVL_W    = PTR_W + 1;
    localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    // Saturating increment of the hit counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    logic [TS_W-1:0]  ts_cnt_q,    ts_cnt_d;
    logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
    logic [LVL_W-1:0] level_q,     level_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic             overflow_q,  overflow_d;

    logic [TS_W-1:0]  mem_q [DEPTH];

    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    always_comb begin
        empty = (level_q == '0);
        full  = (level_q == FULL_LVL);

        // clr wins over everything: a coincident hit or pop is discarded.
        pop   = !clr && !empty && ts_if.ts_ready;
        // A full FIFO still accepts a push when the head leaves the same cycle.
        push  = !clr && hit && (!full || pop);

        // Timestamp counter wraps naturally and is untouched by clr.
        ts_cnt_d    = ts_cnt_q + TS_W'(1);

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        hit_count_d = hit_count_q;
        overflow_d  = overflow_q;

        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            hit_count_d = '0;
            overflow_d  = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
            // Dropped hits are still counted.
            if (hit) begin
                hit_count_d = sat_inc(hit_count_q);
            end
            if (hit && !push) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_cnt_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            hit_count_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            ts_cnt_q    <= ts_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            hit_count_q <= hit_count_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage needs no reset: an entry is only visible once level covers it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ts_cnt_q;
        end
    end

    assign ts_if.ts_valid = !empty;
    assign ts_if.ts_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign level          = level_q;
    assign hit_count      = hit_count_q;
    assign overflow       = overflow_q;
endmodule

// File: tb/tb_seq_hit_logger.sv
module tb_seq_hit_logger;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: TS_W=16, DEPTH=4, CNT_W=8
    logic       rst, hit, clr;
    logic [2:0] lvl;
    logic [7:0] cnt;
    logic       ovf;
    seq_hit_logger_if #(.TS_W(16)) mif ();

    seq_hit_logger #(.TS_W(16), .DEPTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .hit       (hit),
        .clr       (clr),
        .ts_if     (mif),
        .level     (lvl),
        .hit_count (cnt),
        .overflow  (ovf)
    );

    // Small instance: TS_W=4, DEPTH=4, CNT_W=3 for saturation and wrap
    logic       rst_s, hit_s, clr_s;
    logic [2:0] lvl_s;
    logic [2:0] cnt_s;
    logic       ovf_s;
    seq_hit_logger_if #(.TS_W(4)) sif ();

    seq_hit_logger #(.TS_W(4), .DEPTH(4), .CNT_W(3)) dut_s (
        .clk       (clk),
        .rst       (rst_s),
        .hit       (hit_s),
        .clr       (clr_s),
        .ts_if     (sif),
        .level     (lvl_s),
        .hit_count (cnt_s),
        .overflow  (ovf_s)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        hit;
        logic        rdy;
        logic        clr;
        logic        v;
        logic [15:0] d;
        logic [2:0]  l;
        logic [7:0]  c;
        logic        o;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic h, input logic r, input logic c_in,
                       input logic v, input int d, input int l, input int c,
                       input logic o);
        vec_t e;
        e.hit = h; e.rdy = r; e.clr = c_in; e.v = v;
        e.d = 16'(d); e.l = 3'(l); e.c = 8'(c); e.o = o;
        tbl.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; hit = 1'b0; clr = 1'b0; mif.ts_ready = 1'b0;
        rst_s = 1'b0; hit_s = 1'b0; clr_s = 1'b0; sif.ts_ready = 1'b0;

        // Reset held for 3 cycles: every output must read 0.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_valid", mif.ts_valid, 0);
            chk("rst_data",  mif.ts_data,  0);
            chk("rst_level", lvl, 0);
            chk("rst_count", cnt, 0);
            chk("rst_ovf",   ovf, 0);
            chk("rst_s_level", lvl_s, 0);
        end
        rst = 1'b1;  // released 1 time unit after an edge: next edge sees ts_cnt=0

        // Table entry i is applied at the edge whose pre-edge ts_cnt is i.
        for (int i = 0; i < 5; i++) add(0,0,0, 0,0,0,0,0);          // 0-4
        add(1,0,0, 1,5,1,1,0);                                       // 5  push ts 5
        add(0,1,0, 0,0,0,1,0);                                       // 6  pop
        for (int i = 0; i < 3; i++) add(0,0,0, 0,0,0,1,0);          // 7-9
        add(1,0,0, 1,10,1,2,0);                                      // 10
        add(1,0,0, 1,10,2,3,0);                                      // 11
        for (int i = 0; i < 8; i++) add(0,0,0, 1,10,2,3,0);         // 12-19
        add(1,0,0, 1,10,3,4,0);                                      // 20
        add(0,1,0, 1,11,2,4,0);                                      // 21 drain
        add(0,1,0, 1,20,1,4,0);                                      // 22
        add(0,1,0, 0,0,0,4,0);                                       // 23 empty
        add(0,1,0, 0,0,0,4,0);                                       // 24 ready on empty
        add(1,1,0, 1,25,1,5,0);                                      // 25 hit+ready on empty
        add(0,1,0, 0,0,0,5,0);                                       // 26
        add(1,0,0, 1,27,1,6,0);                                      // 27 six hits
        add(1,0,0, 1,27,2,7,0);                                      // 28
        add(1,0,0, 1,27,3,8,0);                                      // 29
        add(1,0,0, 1,27,4,9,0);                                      // 30 full
        add(1,0,0, 1,27,4,10,1);                                     // 31 dropped
        add(1,0,0, 1,27,4,11,1);                                     // 32 dropped
        add(0,1,0, 1,28,3,11,1);                                     // 33 drain
        add(0,1,0, 1,29,2,11,1);                                     // 34
        add(0,1,0, 1,30,1,11,1);                                     // 35
        add(0,1,0, 0,0,0,11,1);                                      // 36
        add(1,0,1, 0,0,0,0,0);                                       // 37 clr + hit
        add(1,0,0, 1,38,1,1,0);                                      // 38 refill
        add(1,0,0, 1,38,2,2,0);                                      // 39
        add(1,0,0, 1,38,3,3,0);                                      // 40
        add(1,0,0, 1,38,4,4,0);                                      // 41 full
        add(1,1,0, 1,39,4,5,0);                                      // 42 push+pop on full
        add(0,1,0, 1,40,3,5,0);                                      // 43
        add(0,1,0, 1,41,2,5,0);                                      // 44
        add(0,1,0, 1,42,1,5,0);                                      // 45 newest is 4th
        add(0,1,0, 0,0,0,5,0);                                       // 46

        foreach (tbl[i]) begin
            hit = tbl[i].hit; mif.ts_ready = tbl[i].rdy; clr = tbl[i].clr;
            tick();
            chk($sformatf("valid[%0d]", i), mif.ts_valid, tbl[i].v);
            chk($sformatf("data[%0d]",  i), mif.ts_data,  tbl[i].d);
            chk($sformatf("level[%0d]", i), lvl, tbl[i].l);
            chk($sformatf("count[%0d]", i), cnt, tbl[i].c);
            chk($sformatf("ovf[%0d]",   i), ovf, tbl[i].o);
        end
        hit = 1'b0; clr = 1'b0; mif.ts_ready = 1'b0;

        // Async reset mid-operation: build level=3 with overflow=1.
        for (int i = 0; i < 5; i++) begin
            hit = 1'b1;
            tick();
        end
        hit = 1'b0; mif.ts_ready = 1'b1;
        tick();
        mif.ts_ready = 1'b0;
        chk("pre_rst_level", lvl, 3);
        chk("pre_rst_ovf",   ovf, 1);
        #2;
        rst = 1'b0;          // between edges
        #1;
        chk("arst_valid", mif.ts_valid, 0);
        chk("arst_data",  mif.ts_data,  0);
        chk("arst_level", lvl, 0);
        chk("arst_count", cnt, 0);
        chk("arst_ovf",   ovf, 0);
        tick();
        rst = 1'b1;
        hit = 1'b1;
        tick();              // first edge after release: pre-edge ts_cnt = 0
        hit = 1'b0;
        chk("post_rst_valid", mif.ts_valid, 1);
        chk("post_rst_data",  mif.ts_data,  0);
        chk("post_rst_level", lvl, 1);
        chk("post_rst_count", cnt, 1);
        mif.ts_ready = 1'b1;
        tick();
        mif.ts_ready = 1'b0;
        chk("post_rst_empty_valid", mif.ts_valid, 0);
        chk("post_rst_empty_level", lvl, 0);

        // Small instance: saturation at 7 and timestamp wrap 15 -> 0.
        rst_s = 1'b1;
        for (int k = 0; k < 18; k++) begin
            hit_s = 1'b1; sif.ts_ready = 1'b1;
            tick();
            chk($sformatf("sat_count[%0d]", k), cnt_s, (k + 1 > 7) ? 7 : k + 1);
            chk($sformatf("wrap_data[%0d]", k), sif.ts_data, k % 16);
            chk($sformatf("s_level[%0d]",   k), lvl_s, 1);
            chk($sformatf("s_ovf[%0d]",     k), ovf_s, 0);
        end
        for (int k = 18; k < 22; k++) begin
            hit_s = 1'b1; sif.ts_ready = 1'b0;
            tick();
        end
        chk("s_full_level", lvl_s, 4);
        chk("s_full_ovf",   ovf_s, 1);
        chk("s_full_count", cnt_s, 7);
        chk("s_full_head",  sif.ts_data, 1);
        hit_s = 1'b1; clr_s = 1'b1;
        tick();
        chk("clr_level", lvl_s, 0);
        chk("clr_valid", sif.ts_valid, 0);
        chk("clr_data",  sif.ts_data, 0);
        chk("clr_count", cnt_s, 0);
        chk("clr_ovf",   ovf_s, 0);
        hit_s = 1'b0; clr_s = 1'b0;
        tick();
        chk("clr_hit_dropped_level", lvl_s, 0);
        chk("clr_hit_dropped_count", cnt_s, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_hit_logger.md
# seq_hit_logger

Downstream consumer of the 1001 sequence detector's single-cycle `out` pulse. Time-stamps every detection against a free-running cycle counter and queues the timestamps in a small FIFO drained over a valid/ready interface. Also keeps a saturating total hit count and a sticky overflow flag. Lets the host read back when and how often the pattern was seen, without having to sample the detector every cycle.

## Interface
- `TS_W`, 16, timestamp counter and FIFO entry width
- `DEPTH`, 4, FIFO depth in entries; power of two, ≥2
- `CNT_W`, 8, hit counter width
- `clk`  in  1  clock; all logic rising-edge
- `rst`  in  1  asynchronous, active-low reset (0 = reset)
- `hit`  in  1  detection pulse from the sequence detector; one event per high cycle
- `clr`  in  1  synchronous clear of FIFO, `hit_count` and `overflow`
- `ts_ready`  in  1  consumer ready to accept head entry
- `ts_valid`  out  1  FIFO non-empty; head entry on `ts_data`
- `ts_data`  out  TS_W  head timestamp; 0 when FIFO empty
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
- `hit_count`  out  CNT_W  total hits since reset/clr, saturating
- `overflow`  out  1  sticky: a hit was dropped because the FIFO was full

## Operation
- Timestamp counter `ts_cnt`:
  - Increments by 1 every cycle and wraps from 2^TS_W−1 to 0.
  - Not affected by `clr`; reset only by `rst`.
- Push: `hit`=1 at a rising edge writes the `ts_cnt` value present before that edge.
- Pop: `ts_valid`=1 and `ts_ready`=1 at a rising edge removes the head entry. `ts_ready` is ignored when empty.
- Ordering: FIFO order; circular write/read pointers of $clog2(DEPTH) bits, wrapping at DEPTH.
- Full, `hit` with no pop: entry dropped, `level` unchanged, `overflow` set to 1.
- Full, `hit` with pop in the same cycle: pop and push both succeed; `level` stays DEPTH; no overflow.
- Empty, `hit` with `ts_ready`=1: no pop (nothing valid); push succeeds; `level` becomes 1.
- `hit_count`: +1 on every `hit`, including dropped ones; holds at 2^CNT_W−1 once reached.
- `overflow`: cleared only by `rst` or `clr`.
- `clr`:
  - Highest priority over everything else.
  - Empties the FIFO (pointers to 0) and zeroes `hit_count` and `overflow`.
  - A `hit` or pop in the same cycle is ignored.
- Reset asserted: all state forced immediately, regardless of clock; an in-progress drain is abandoned.
- Reset values: `ts_cnt`=0, `level`=0, `ts_valid`=0, `ts_data`=0, `hit_count`=0, `overflow`=0.

## Timing
- All outputs are registered or decoded from registers only; there is no combinational path from any input to any output.
- Push latency is one edge. `hit` sampled at edge N with pre-edge `ts_cnt`=T, FIFO empty → after edge N: `ts_valid`=1, `ts_data`=T, `level`=1.
- Pop latency is one edge. Head advances after the accepting edge; the next entry (or 0 when emptied) appears after that edge.
- Sustained throughput: one push and one pop per cycle.
- Back-to-back `hit` pulses in consecutive cycles produce consecutive timestamps T, T+1 (mod 2^TS_W).
- Overflow: `overflow` rises after the edge where the dropped `hit` was sampled.
- Reset release: first `ts_cnt` increment occurs at the first rising edge with `rst`=1.

## Test plan
- Reset/basic push:
  - Stimulus: `rst` low 3 cycles, release; `hit` pulse when `ts_cnt`=5.
  - Required: all outputs 0 during reset; next cycle `ts_valid`=1, `ts_data`=5, `level`=1, `hit_count`=1.
- FIFO order and drain:
  - Stimulus: `ts_ready`=0; hits at `ts_cnt`=10,11,20; then `ts_ready`=1.
  - Required: `ts_data` reads 10, 11, 20 on consecutive cycles; `ts_valid` drops and `ts_data`=0 after the third pop; `level` steps 3→2→1→0.
- Overflow:
  - Stimulus: `ts_ready`=0; 6 hits.
  - Required: `level`=4, `overflow`=1, `hit_count`=6; drain returns the first 4 timestamps only.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full; one cycle with `hit`=1 and `ts_ready`=1.
  - Required: `level` stays 4, `overflow` stays 0, the newest timestamp appears as the 4th entry.
- Saturation, clr and wrap:
  - Stimulus: `CNT_W`=3 with 9 hits; then `clr` coincident with `hit`; separately, run `TS_W`=4 past 15.
  - Required: `hit_count` holds at 7; after `clr`, `level`=0, `hit_count`=0, `overflow`=0, the coincident hit is not logged; timestamps wrap 15→0.
- Async reset mid-operation:
  - Stimulus: `rst` low between clock edges with `level`=3, `overflow`=1.
  - Required: outputs go to 0 before the next edge; the previously queued entries are not seen after release.
